serial_divider_driver: RTL and testbench
========================================

SERIAL_DIVIDER_DRIVER -- requirements
Module: serial_divider_driver

Interface
REQ-001 Parameters SHALL be:
- WBW = 32: Wishbone data/address width.
- XLEN = 32: operand width.
- ACK_TIMEOUT = 64: maximum cycles to wait for wbm_ack_i.
- POLL_MAX = 256: maximum STATUS reads per job.
- ADR_DIVIDEND = 32'h1000_0000, ADR_DIVISOR = 32'h2000_0000, ADR_QUOTIENT = 32'h3000_0000, ADR_REMAINDER = 32'h4000_0000: argument/result register addresses.
- ADR_CTRL = 32'h0100_0000: control register, bit0 = start.
- ADR_STATUS = 32'h0200_0000: status register, bit0 = done.
REQ-002 Ports SHALL be:
- clk_i  in  1  sole clock, all logic on rising edge.
- reset_ni  in  1  synchronous reset, active-low.
- op_valid_i  in  1  job offered.
- op_ready_o  out  1  job accepted when high with op_valid_i.
- op_dividend_i  in  XLEN  dividend.
- op_divisor_i  in  XLEN  divisor.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  result consumed.
- res_quotient_o  out  XLEN  quotient.
- res_remainder_o  out  XLEN  remainder.
- res_div0_o  out  1  divisor was zero.
- res_err_o  out  1  bus timeout or poll limit hit.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master control.
- wbm_sel_o  out  WBW/8  byte select.
- wbm_adr_o  out  WBW  address.
- wbm_dat_o  out  WBW  write data.
- wbm_dat_i  in  WBW  read data.
- wbm_ack_i  in  1  slave acknowledge.

Function
REQ-003 The block SHALL be a Wishbone classic master that feeds one job at a time into the serial divider's slave port and returns the result on a valid/ready stream.
REQ-004 The FSM states SHALL be IDLE, WR_DVD, WR_DVS, WR_GO, RD_STAT, RD_Q, RD_R, GAP, RESP.
REQ-005 op_ready_o SHALL be high only in IDLE; a handshake SHALL register both operands and leave IDLE on the next edge.
REQ-006 A registered divisor of 0 SHALL go directly to RESP with no bus traffic, giving quotient = all ones, remainder = dividend, res_div0_o = 1, res_err_o = 0.
REQ-007 A nonzero divisor SHALL run WR_DVD -> WR_DVS -> WR_GO (data 1) -> RD_STAT, repeated until dat_i[0] = 1 -> RD_Q -> RD_R -> RESP.
REQ-008 Each bus state SHALL be one transfer with cyc = stb = 1, sel = all ones, we = 1 for writes and 0 for reads; signals SHALL be held stable until wbm_ack_i.
REQ-009 After every ack the block SHALL enter GAP, driving cyc = stb = 0 for exactly one cycle before the next transfer (no back-to-back transfers).
REQ-010 Read data SHALL be captured on the ack cycle: RD_Q into quotient, RD_R into remainder.
REQ-011 The ack wait counter SHALL reset at each transfer start; when it reaches ACK_TIMEOUT the block SHALL drop cyc/stb and enter RESP with res_err_o = 1, quotient = remainder = 0.
REQ-012 The poll counter SHALL count STATUS reads; reaching POLL_MAX reads without done SHALL end the job as in REQ-011.
REQ-013 In RESP, res_valid_o SHALL be 1 and all res_* outputs SHALL be held stable until res_ready_i; the handshake cycle SHALL return the block to IDLE.
REQ-014 wbm_dat_o SHALL be 0 during reads; wbm_adr_o/wbm_dat_o SHALL be 0 whenever cyc = 0.
REQ-015 A wbm_ack_i arriving while cyc = 0 SHALL be ignored.

Reset
REQ-016 When reset_ni = 0 at an edge, the block SHALL enter IDLE and clear both counters and all outputs to 0, except op_ready_o = 1 from the first cycle after reset.
REQ-017 A reset in mid-transfer SHALL deassert cyc/stb on the next edge and discard the job; no res_valid_o SHALL follow.

Verification
REQ-018 Dividend 100, divisor 25, slave acks in 1 cycle, done on 3rd poll -> writes appear in order DVD/DVS/CTRL, each separated by an idle cycle; result quotient 4, remainder 0, div0 0, err 0.
REQ-019 Dividend 7, divisor 0 -> no cyc assertion; result valid 2 cycles after accept with quotient FFFF_FFFF, remainder 7, div0 1.
REQ-020 Slave never acks the first write -> cyc drops after 64 cycles; result err 1, quotient 0.
REQ-021 Dividend 17, divisor 5, res_ready_i held low 10 cycles -> quotient 3, remainder 2 held stable throughout; op_ready_o stays 0 until the result handshake.
REQ-022 reset_ni pulsed low during RD_STAT -> cyc = 0 on the next cycle, no result; a following job 9/3 gives quotient 3, remainder 0.
REQ-023 Done never set -> exactly 256 STATUS reads, then a result with err 1.

Source files
------------

// File: rtl/serial_divider_driver.sv
// serial_divider_driver
// Wishbone classic master that feeds one division job at a time into a serial
// divider peripheral and returns the result on a valid/ready stream.
//
// Ports
//   clk_i, reset_ni            clock (rising edge) and synchronous active-low reset
//   op_valid_i / op_ready_o    job handshake, operands op_dividend_i / op_divisor_i
//   res_valid_o / res_ready_i  result handshake
//   res_quotient_o, res_remainder_o, res_div0_o, res_err_o  result payload
//   wbm_*                      Wishbone classic master port
//
// Job flow: write dividend, write divisor, write CTRL.start, poll STATUS.done,
// read quotient, read remainder. A zero divisor is answered locally with no bus
// traffic. Every acked transfer is followed by one idle GAP cycle. A transfer
// that is not acked within ACK_TIMEOUT cycles, or POLL_MAX STATUS reads without
// done, ends the job with res_err_o set.
module serial_divider_driver #(
  parameter int unsigned     WBW           = 32,
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     ACK_TIMEOUT   = 64,
  parameter int unsigned     POLL_MAX      = 256,
  parameter logic [WBW-1:0]  ADR_DIVIDEND  = 32'h1000_0000,
  parameter logic [WBW-1:0]  ADR_DIVISOR   = 32'h2000_0000,
  parameter logic [WBW-1:0]  ADR_QUOTIENT  = 32'h3000_0000,
  parameter logic [WBW-1:0]  ADR_REMAINDER = 32'h4000_0000,
  parameter logic [WBW-1:0]  ADR_CTRL      = 32'h0100_0000,
  parameter logic [WBW-1:0]  ADR_STATUS    = 32'h0200_0000
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [XLEN-1:0]   op_dividend_i,
  input  logic [XLEN-1:0]   op_divisor_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [XLEN-1:0]   res_quotient_o,
  output logic [XLEN-1:0]   res_remainder_o,
  output logic              res_div0_o,
  output logic              res_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [WBW/8-1:0]  wbm_sel_o,
  output logic [WBW-1:0]    wbm_adr_o,
  output logic [WBW-1:0]    wbm_dat_o,
  input  logic [WBW-1:0]    wbm_dat_i,
  input  logic              wbm_ack_i
);

  localparam int ACW = $clog2(ACK_TIMEOUT + 1);
  localparam int PCW = $clog2(POLL_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, WR_DVD, WR_DVS, WR_GO, RD_STAT, RD_Q, RD_R, GAP, RESP
  } state_t;

  state_t           state_r, state_nxt;
  state_t           gap_to_r, gap_to_nxt;
  state_t           after_ack;
  logic [XLEN-1:0]  dvd_r, dvd_nxt;
  logic [XLEN-1:0]  dvs_r, dvs_nxt;
  logic [XLEN-1:0]  quo_r, quo_nxt;
  logic [XLEN-1:0]  rem_r, rem_nxt;
  logic             div0_r, div0_nxt;
  logic             err_r, err_nxt;
  logic [ACW-1:0]   ack_cnt_r, ack_cnt_nxt;
  logic [PCW-1:0]   poll_cnt_r, poll_cnt_nxt;
  logic             bus_req, bus_we, fail;
  logic [WBW-1:0]   bus_adr, bus_dat;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_r    <= IDLE;
      gap_to_r   <= IDLE;
      dvd_r      <= '0;
      dvs_r      <= '0;
      quo_r      <= '0;
      rem_r      <= '0;
      div0_r     <= 1'b0;
      err_r      <= 1'b0;
      ack_cnt_r  <= '0;
      poll_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt;
      gap_to_r   <= gap_to_nxt;
      dvd_r      <= dvd_nxt;
      dvs_r      <= dvs_nxt;
      quo_r      <= quo_nxt;
      rem_r      <= rem_nxt;
      div0_r     <= div0_nxt;
      err_r      <= err_nxt;
      ack_cnt_r  <= ack_cnt_nxt;
      poll_cnt_r <= poll_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_r;
    gap_to_nxt   = gap_to_r;
    dvd_nxt      = dvd_r;
    dvs_nxt      = dvs_r;
    quo_nxt      = quo_r;
    rem_nxt      = rem_r;
    div0_nxt     = div0_r;
    err_nxt      = err_r;
    ack_cnt_nxt  = ack_cnt_r;
    poll_cnt_nxt = poll_cnt_r;
    after_ack    = IDLE;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_adr      = '0;
    bus_dat      = '0;
    fail         = 1'b0;

    case (state_r)
      IDLE: begin
        if (op_valid_i) begin
          dvd_nxt      = op_dividend_i;
          dvs_nxt      = op_divisor_i;
          quo_nxt      = '0;
          rem_nxt      = '0;
          div0_nxt     = 1'b0;
          err_nxt      = 1'b0;
          ack_cnt_nxt  = '0;
          poll_cnt_nxt = '0;
          state_nxt    = WR_DVD;
        end
      end
      WR_DVD: begin
        // Division by zero is answered locally; the bus stays idle.
        if (dvs_r == '0) begin
          quo_nxt   = '1;
          rem_nxt   = dvd_r;
          div0_nxt  = 1'b1;
          state_nxt = RESP;
        end else begin
          bus_req   = 1'b1;
          bus_we    = 1'b1;
          bus_adr   = ADR_DIVIDEND;
          bus_dat   = WBW'(dvd_r);
          after_ack = WR_DVS;
        end
      end
      WR_DVS: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_adr   = ADR_DIVISOR;
        bus_dat   = WBW'(dvs_r);
        after_ack = WR_GO;
      end
      WR_GO: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_adr   = ADR_CTRL;
        bus_dat   = WBW'(1);
        after_ack = RD_STAT;
      end
      RD_STAT: begin
        bus_req = 1'b1;
        bus_adr = ADR_STATUS;
        if (wbm_dat_i[0]) begin
          after_ack = RD_Q;
        end else if (poll_cnt_r == PCW'(POLL_MAX - 1)) begin
          after_ack = RESP;
        end else begin
          after_ack = RD_STAT;
        end
        if (wbm_ack_i) begin
          poll_cnt_nxt = poll_cnt_r + PCW'(1);
          // Last permitted poll still not done: abort through the GAP cycle.
          if (!wbm_dat_i[0] && poll_cnt_r == PCW'(POLL_MAX - 1)) fail = 1'b1;
        end
      end
      RD_Q: begin
        bus_req   = 1'b1;
        bus_adr   = ADR_QUOTIENT;
        after_ack = RD_R;
        if (wbm_ack_i) quo_nxt = XLEN'(wbm_dat_i);
      end
      RD_R: begin
        bus_req   = 1'b1;
        bus_adr   = ADR_REMAINDER;
        after_ack = RESP;
        if (wbm_ack_i) rem_nxt = XLEN'(wbm_dat_i);
      end
      GAP: begin
        state_nxt = gap_to_r;
      end
      RESP: begin
        if (res_ready_i) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Shared ack/timeout handling for every bus state; ack wins over timeout.
    if (bus_req) begin
      if (wbm_ack_i) begin
        state_nxt   = GAP;
        gap_to_nxt  = after_ack;
        ack_cnt_nxt = '0;
      end else if (ack_cnt_r == ACW'(ACK_TIMEOUT - 1)) begin
        state_nxt = RESP;
        fail      = 1'b1;
      end else begin
        ack_cnt_nxt = ack_cnt_r + ACW'(1);
      end
    end

    if (fail) begin
      err_nxt = 1'b1;
      quo_nxt = '0;
      rem_nxt = '0;
    end
  end

  assign wbm_cyc_o       = bus_req;
  assign wbm_stb_o       = bus_req;
  assign wbm_we_o        = bus_we;
  assign wbm_sel_o       = bus_req ? '1 : '0;
  assign wbm_adr_o       = bus_adr;
  assign wbm_dat_o       = bus_dat;
  assign op_ready_o      = (state_r == IDLE);
  assign res_valid_o     = (state_r == RESP);
  assign res_quotient_o  = quo_r;
  assign res_remainder_o = rem_r;
  assign res_div0_o      = div0_r;
  assign res_err_o       = err_r;

endmodule

// File: tb/tb_serial_divider_driver.sv
// tb_serial_divider_driver
// Bench for serial_divider_driver: a behavioural divider slave on the Wishbone
// side, directed and randomized jobs, and a spec-level result model.
module tb_serial_divider_driver;
  localparam int WBW = 32;
  localparam int XLEN = 32;
  localparam int POLL_MAX = 256;
  localparam logic [31:0] A_DVD  = 32'h1000_0000;
  localparam logic [31:0] A_DVS  = 32'h2000_0000;
  localparam logic [31:0] A_Q    = 32'h3000_0000;
  localparam logic [31:0] A_R    = 32'h4000_0000;
  localparam logic [31:0] A_CTRL = 32'h0100_0000;
  localparam logic [31:0] A_STAT = 32'h0200_0000;

  logic            clk_i = 1'b0;
  logic            reset_ni = 1'b0;
  logic            op_valid_i = 1'b0;
  logic            op_ready_o;
  logic [XLEN-1:0] op_dividend_i = '0;
  logic [XLEN-1:0] op_divisor_i = '0;
  logic            res_valid_o;
  logic            res_ready_i = 1'b0;
  logic [XLEN-1:0] res_quotient_o, res_remainder_o;
  logic            res_div0_o, res_err_o;
  logic            wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [WBW/8-1:0] wbm_sel_o;
  logic [WBW-1:0]  wbm_adr_o, wbm_dat_o;
  logic [WBW-1:0]  wbm_dat_i = '0;
  logic            wbm_ack_i = 1'b0;

  serial_divider_driver dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_dividend_i(op_dividend_i), .op_divisor_i(op_divisor_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_quotient_o(res_quotient_o), .res_remainder_o(res_remainder_o),
    .res_div0_o(res_div0_o), .res_err_o(res_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave behaviour knobs
  int  lat = 0;          // wait cycles before ack
  int  done_after = 3;   // STATUS read number that first reports done; 0 = never
  bit  ack_en = 1'b1;
  bit  stray = 1'b0;     // drive ack while the bus is idle

  // Slave state and protocol observations
  logic [31:0] s_dvd = '0, s_dvs = '0;
  int  polls = 0, stat_reads = 0, wcnt = 0;
  logic [31:0] wr_adr[$];
  logic [31:0] wr_dat[$];
  int  idle_viol = 0, rd_viol = 0, b2b_viol = 0, stab_viol = 0, sel_viol = 0, adr_viol = 0;
  int  cyc_run = 0, last_run = 0;
  bit  cyc_seen = 1'b0, prev_xfer = 1'b0, in_xfer = 1'b0;
  logic [31:0] h_adr, h_dat;
  logic h_we;

  always @(negedge clk_i) begin
    if (!wbm_cyc_o) begin
      if (wbm_stb_o || wbm_we_o || wbm_adr_o != 0 || wbm_dat_o != 0 || wbm_sel_o != 0) idle_viol++;
      if (cyc_run != 0) last_run = cyc_run;
      cyc_run = 0;
      in_xfer = 1'b0;
    end else begin
      cyc_seen = 1'b1;
      cyc_run++;
      if (!wbm_stb_o || wbm_sel_o != 4'hF) sel_viol++;
      if (!wbm_we_o && wbm_dat_o != 0) rd_viol++;
      if (prev_xfer) b2b_viol++;
      if (in_xfer && (wbm_adr_o != h_adr || wbm_dat_o != h_dat || wbm_we_o != h_we)) stab_viol++;
      if (!in_xfer) begin
        in_xfer = 1'b1;
        h_adr = wbm_adr_o; h_dat = wbm_dat_o; h_we = wbm_we_o;
      end
    end
    prev_xfer = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    if (wbm_cyc_o && wbm_stb_o) begin
      if (ack_en) begin
        if (wcnt >= lat) begin
          wcnt = 0;
          wbm_ack_i = 1'b1;
          prev_xfer = 1'b1;
          in_xfer = 1'b0;
          if (wbm_we_o) begin
            wr_adr.push_back(wbm_adr_o);
            wr_dat.push_back(wbm_dat_o);
            if (wbm_adr_o == A_DVD) s_dvd = wbm_dat_o;
            else if (wbm_adr_o == A_DVS) s_dvs = wbm_dat_o;
            else if (wbm_adr_o == A_CTRL) begin if (wbm_dat_o[0]) polls = 0; end
            else adr_viol++;
          end else begin
            if (wbm_adr_o == A_STAT) begin
              polls++;
              stat_reads++;
              wbm_dat_i = (done_after != 0 && polls >= done_after) ? 32'd1 : 32'd0;
            end else if (wbm_adr_o == A_Q) wbm_dat_i = (s_dvs != 0) ? s_dvd / s_dvs : 32'd0;
            else if (wbm_adr_o == A_R) wbm_dat_i = (s_dvs != 0) ? s_dvd % s_dvs : 32'd0;
            else adr_viol++;
          end
        end else begin
          wcnt++;
        end
      end
    end else begin
      wcnt = 0;
      if (stray && !wbm_cyc_o) wbm_ack_i = 1'b1;
    end
  end

  // Expected outcome of one job from the requirements, given the slave knobs.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic d0, output logic er,
                                output int nwr, output int nrd);
    d0 = 1'b0; er = 1'b0; q = '0; r = '0; nwr = 3; nrd = 0;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; d0 = 1'b1; nwr = 0;
    end else if (!ack_en) begin
      er = 1'b1; nwr = 0;
    end else if (done_after == 0 || done_after > POLL_MAX) begin
      er = 1'b1; nrd = POLL_MAX;
    end else begin
      q = a / b; r = a % b; nrd = done_after;
    end
  endfunction

  int last_lat = 0;

  task automatic run_job(input string nm, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] eq, er, q0, r0;
    logic ed0, eerr, d0, e0;
    int ewr, erd, n, unstable, busy_rdy;
    logic [31:0] ea[3];
    logic [31:0] ed[3];
    model(a, b, eq, er, ed0, eerr, ewr, erd);
    ea[0] = A_DVD; ea[1] = A_DVS; ea[2] = A_CTRL;
    ed[0] = a;     ed[1] = b;     ed[2] = 32'd1;
    wr_adr.delete(); wr_dat.delete();
    stat_reads = 0; cyc_seen = 1'b0;
    @(negedge clk_i);
    chk({nm, "_ready_idle"}, op_ready_o, 1);
    op_valid_i = 1'b1; op_dividend_i = a; op_divisor_i = b;
    @(negedge clk_i);
    n = 1; unstable = 0; busy_rdy = 0;
    op_valid_i = 1'b0; op_dividend_i = $urandom; op_divisor_i = $urandom;
    while (!res_valid_o && n < 2000) begin
      if (op_ready_o) busy_rdy++;
      @(negedge clk_i);
      n++;
    end
    last_lat = n;
    chk({nm, "_res_valid"}, res_valid_o, 1);
    q0 = res_quotient_o; r0 = res_remainder_o; d0 = res_div0_o; e0 = res_err_o;
    for (int i = 0; i < hold; i++) begin
      if (op_ready_o) busy_rdy++;
      @(negedge clk_i);
      if (!res_valid_o || res_quotient_o != q0 || res_remainder_o != r0 ||
          res_div0_o != d0 || res_err_o != e0) unstable++;
    end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    chk({nm, "_quotient"}, q0, eq);
    chk({nm, "_remainder"}, r0, er);
    chk({nm, "_div0"}, d0, ed0);
    chk({nm, "_err"}, e0, eerr);
    chk({nm, "_writes"}, wr_adr.size(), ewr);
    chk({nm, "_status_reads"}, stat_reads, erd);
    chk({nm, "_hold_stable"}, unstable, 0);
    chk({nm, "_ready_busy"}, busy_rdy, 0);
    chk({nm, "_ready_after"}, op_ready_o, 1);
    chk({nm, "_valid_after"}, res_valid_o, 0);
    for (int i = 0; i < ewr && i < wr_adr.size(); i++) begin
      chk({nm, "_wr_adr"}, wr_adr[i], ea[i]);
      chk({nm, "_wr_dat"}, wr_dat[i], ed[i]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, n;
    logic [31:0] a, b;
    // Reset state
    reset_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_op_ready", op_ready_o, 1);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_cyc", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
    chk("rst_adr_dat", {wbm_adr_o, wbm_dat_o}, 0);
    chk("rst_results", {res_quotient_o, res_remainder_o, res_div0_o, res_err_o}, 0);
    reset_ni = 1'b1;

    // Basic job: 100/25, ack after 1 cycle, done on third poll
    ack_en = 1'b1; lat = 0; done_after = 3;
    run_job("basic", 32'd100, 32'd25, 0);

    // Divide by zero, with stray acks while the bus is idle
    stray = 1'b1;
    run_job("div0", 32'd7, 32'd0, 0);
    stray = 1'b0;
    chk("div0_latency", last_lat, 2);
    chk("div0_no_cyc", cyc_seen, 0);

    // Slave never acks
    ack_en = 1'b0; last_run = 0;
    run_job("ack_tmo", 32'd55, 32'd5, 0);
    chk("ack_tmo_cyc_len", last_run, 64);
    ack_en = 1'b1;

    // Result held under backpressure
    lat = 1; done_after = 2;
    run_job("hold", 32'd17, 32'd5, 10);

    // Reset while polling STATUS
    lat = 2; done_after = 0;
    @(negedge clk_i);
    op_valid_i = 1'b1; op_dividend_i = 32'd50; op_divisor_i = 32'd7;
    @(negedge clk_i);
    op_valid_i = 1'b0;
    n = 0;
    while (!(wbm_cyc_o && wbm_adr_o == A_STAT) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("midrst_reach_stat", wbm_adr_o, A_STAT);
    reset_ni = 1'b0;
    @(negedge clk_i);
    chk("midrst_cyc", wbm_cyc_o, 0);
    chk("midrst_ready", op_ready_o, 1);
    reset_ni = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (res_valid_o) seen++;
    end
    chk("midrst_no_result", seen, 0);
    lat = 0; done_after = 2;
    run_job("after_rst", 32'd9, 32'd3, 0);

    // Done never set
    lat = 0; done_after = 0;
    run_job("poll_lim", 32'd1000, 32'd7, 0);

    // Randomized jobs
    for (int k = 0; k < 10; k++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = $urandom_range(2, 16);
        default: b = $urandom;
      endcase
      lat = $urandom_range(0, 3);
      done_after = $urandom_range(1, 5);
      run_job("rnd", a, b, $urandom_range(0, 3));
    end

    // Bus protocol observations over the whole run
    chk("proto_idle_zero", idle_viol, 0);
    chk("proto_read_dat", rd_viol, 0);
    chk("proto_gap", b2b_viol, 0);
    chk("proto_stable", stab_viol, 0);
    chk("proto_sel_stb", sel_viol, 0);
    chk("proto_addr", adr_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
